// File: rtl/serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder controller: state encoding
// and the slice width of the shared ripple adder.
package serial_adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/response bundle between a requesting datapath (master) and the
// nibble-serial adder controller (slave).
interface nibble_serial_adder_ctrl_if #(
    parameter int NIBBLES = 4
);
    import serial_adder_pkg::*;

    localparam int W = NIB_W * NIBBLES;

    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         C_in;
    logic         busy;
    logic         done;
    logic [W-1:0] SUM;
    logic         C_out;

    modport master (
        output start, A, B, C_in,
        input  busy, done, SUM, C_out
    );

    modport slave (
        input  start, A, B, C_in,
        output busy, done, SUM, C_out
    );

endinterface

// File: rtl/ripple_addr_4_bit.sv
// Shared 4-bit ripple-carry adder: Z/C_out = X + Y + C_in, purely combinational.
module ripple_addr_4_bit (
    input  logic [3:0] X,
    input  logic [3:0] Y,
    input  logic       C_in,
    output logic [3:0] Z,
    output logic       C_out
);

    logic [4:0] w_c;

    assign w_c[0] = C_in;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign Z[i]     = X[i] ^ Y[i] ^ w_c[i];
        assign w_c[i+1] = (X[i] & Y[i]) | (w_c[i] & (X[i] ^ Y[i]));
    end

    assign C_out = w_c[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Steps one shared 4-bit adder over NIBBLES slices, LSB nibble first, keeping
// the inter-nibble carry in a register; returns {C_out, SUM} with a done pulse.
module nibble_serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        CLK,
    input  logic                        RST,
    nibble_serial_adder_ctrl_if.slave   ctrl
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t             r_state;
    logic [W-1:0]       r_a_sh;
    logic [W-1:0]       r_b_sh;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [IDX_W-1:0]   r_idx;
    logic               r_busy;
    logic               r_done;

    logic [NIB_W-1:0]   w_z;
    logic               w_cout;
    logic               w_last;

    ripple_addr_4_bit u_adder (
        .X     (r_a_sh[NIB_W-1:0]),
        .Y     (r_b_sh[NIB_W-1:0]),
        .C_in  (r_carry),
        .Z     (w_z),
        .C_out (w_cout)
    );

    assign w_last = (r_idx == IDX_W'(NIBBLES - 1));

    // NOTE: every register here, datapath included, is cleared by the async
    // reset so an aborted operation leaves no stale operands or partial sum.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every branch sees pre-edge state.
            case (r_state)
                IDLE: begin
                    if (ctrl.start) begin
                        r_a_sh  <= ctrl.A;
                        r_b_sh  <= ctrl.B;
                        r_carry <= ctrl.C_in;
                        r_idx   <= '0;
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    // New nibble enters at the top; after NIBBLES steps it is aligned.
                    r_sum   <= (r_sum >> NIB_W) | (W'(w_z) << (W - NIB_W));
                    r_carry <= w_cout;
                    r_a_sh  <= r_a_sh >> NIB_W;
                    r_b_sh  <= r_b_sh >> NIB_W;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (w_last) begin
                        r_cout  <= w_cout;
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl.busy  = r_busy;
    assign ctrl.done  = r_done;
    assign ctrl.SUM   = r_sum;
    assign ctrl.C_out = r_cout;

endmodule
